bus_memory: RTL

Bus-side responder to the CPU controller's memory strobes. It holds the memory address register (MAR) and a DEPTH×8 RAM on the shared 8-bit tri-state bus:
- latches an address when the controller pulls i_reg_mem_write_n low;
- drives RAM data onto the bus when the controller pulls i_mem_read_n low.

A valid/ready program-load port fills RAM from address 0 while the CPU is held off the bus.

---
 rtl/bus_memory_pkg.sv | 34 +++
 rtl/bus_memory_mem_array.sv | 38 +++
 rtl/bus_memory.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/bus_memory_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bus_memory_pkg                                                 |
// | Purpose  : Shared definitions for the bus-side memory block: loader FSM   |
// |            state encodings, the CPU bus width, and the controller opcode |
// |            set used when assembling program images.                       |
// | Ports    : none (package)                                                 |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package bus_memory_pkg;

  localparam int BUS_W = 8;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

  // Opcodes decoded by the CPU controller (upper nibble of an instruction byte).
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Instruction byte = {opcode, operand address}.
  function automatic logic [BUS_W-1:0] asm_instr(input logic [3:0] op,
                                                 input logic [3:0] operand);
    return {op, operand};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_memory_mem_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_array                                                      |
// | Purpose  : DEPTH x DATA_W storage, one synchronous write port and one     |
// |            asynchronous read port. Contents are not reset.                |
// | Ports    : clk    - write clock                                           |
// |            we     - write enable                                          |
// |            waddr  - write address                                         |
// |            wdata  - write data                                            |
// |            raddr  - read address                                          |
// |            rdata  - read data (combinational)                             |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mem_array #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/bus_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bus_memory                                                     |
// | Purpose  : Bus-side responder to the CPU controller's memory strobes.     |
// |            Holds the MAR and a DEPTH x 8 RAM on the shared tri-state bus, |
// |            plus a valid/ready program loader that fills RAM from address  |
// |            0 while the CPU is held off the bus.                           |
// | Options  : BUS_MEM_WRITE_EN - when defined, i_mem_write_n writes io_bus   |
// |            into mem[MAR]; otherwise RAM is read-only from the bus side.   |
// | Ports    : i_clk, i_reset      - clock, async active-high reset           |
// |            io_bus              - shared 8-bit CPU bus                     |
// |            i_reg_mem_write_n   - latch io_bus[ADDR_W-1:0] into MAR        |
// |            i_mem_read_n        - drive mem[MAR] onto io_bus               |
// |            i_mem_write_n       - write io_bus into mem[MAR] (option)      |
// |            i_prog_mode         - loader owns RAM, bus strobes ignored     |
// |            i_prog_valid/data   - loader byte stream                       |
// |            o_prog_ready/done   - loader handshake / completion            |
// |            o_prog_addr         - next loader write address                |
// |            o_mar               - current MAR                              |
// |            o_bus_conflict      - sticky illegal-strobe flag               |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module bus_memory
  import bus_memory_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16   // must equal 2**ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  inout  wire  [BUS_W-1:0]  io_bus,
  input  logic              i_reg_mem_write_n,
  input  logic              i_mem_read_n,
  input  logic              i_mem_write_n,
  input  logic              i_prog_mode,
  input  logic              i_prog_valid,
  input  logic [BUS_W-1:0]  i_prog_data,
  output logic              o_prog_ready,
  output logic              o_prog_done,
  output logic [ADDR_W-1:0] o_prog_addr,
  output logic [ADDR_W-1:0] o_mar,
  output logic              o_bus_conflict
);

  ld_state_t         state, state_nxt;
  logic [ADDR_W-1:0] prog_addr, prog_addr_nxt;
  logic [ADDR_W-1:0] mar;
  logic              conflict;

  logic              bus_owned;
  logic              rd_req;
  logic              mar_req;
  logic              bus_wr_req;
  logic              bus_wr;
  logic              prog_wr;
  logic              conflict_now;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [BUS_W-1:0]  mem_wdata;
  logic [BUS_W-1:0]  mem_rdata;

  // The CPU owns the bus only in IDLE with prog mode low; this also
  // discards strobes in the IDLE->LOAD transition cycle.
  assign bus_owned = (state == LD_IDLE) && !i_prog_mode;
  assign rd_req    = bus_owned && !i_mem_read_n;
  assign mar_req   = bus_owned && !i_reg_mem_write_n;

`ifdef BUS_MEM_WRITE_EN
  assign bus_wr_req = bus_owned && !i_mem_write_n;
`else
  assign bus_wr_req = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{i_mem_write_n, io_bus[BUS_W-1:ADDR_W]};
`endif

  // A read together with any write-type strobe is illegal; the read still
  // wins the bus and the write side is dropped.
  assign conflict_now = rd_req && (mar_req || bus_wr_req);
  assign bus_wr       = bus_wr_req && i_mem_read_n;
  assign prog_wr      = (state == LD_LOAD) && i_prog_valid;

  // Reset gates the write so a byte in flight at a reset edge is dropped.
  assign mem_we    = (prog_wr || bus_wr) && !i_reset;
  assign mem_waddr = prog_wr ? prog_addr : mar;
  assign mem_wdata = prog_wr ? i_prog_data : io_bus;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .DATA_W (BUS_W)
  ) u_mem (
    .clk   (i_clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mar),
    .rdata (mem_rdata)
  );

  assign io_bus = (rd_req && !i_reset) ? mem_rdata : {BUS_W{1'bz}};

  // Loader FSM state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= LD_IDLE;
      prog_addr <= '0;
    end else begin
      state     <= state_nxt;
      prog_addr <= prog_addr_nxt;
    end
  end

  // Loader FSM next state and outputs
  always_comb begin
    state_nxt     = state;
    prog_addr_nxt = prog_addr;
    o_prog_ready  = 1'b0;
    o_prog_done   = 1'b0;
    case (state)
      LD_IDLE: begin
        if (i_prog_mode) begin
          state_nxt     = LD_LOAD;
          prog_addr_nxt = '0;
        end
      end
      LD_LOAD: begin
        o_prog_ready = 1'b1;
        if (prog_wr) begin
          prog_addr_nxt = prog_addr + 1'b1;
        end
        if (!i_prog_mode || (prog_wr && (prog_addr == ADDR_W'(DEPTH - 1)))) begin
          state_nxt = LD_DONE;
        end
      end
      LD_DONE: begin
        o_prog_done = 1'b1;
        if (!i_prog_mode) begin
          state_nxt = LD_IDLE;
        end
      end
      default: begin
        state_nxt = LD_IDLE;
      end
    endcase
  end

  // MAR and sticky conflict flag
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mar      <= '0;
      conflict <= 1'b0;
    end else begin
      if (mar_req && !conflict_now) begin
        mar <= io_bus[ADDR_W-1:0];
      end
      if (conflict_now) begin
        conflict <= 1'b1;
      end
    end
  end

  assign o_prog_addr    = prog_addr;
  assign o_mar          = mar;
  assign o_bus_conflict = conflict;

endmodule
`default_nettype wire
